wb_serial_master: RTL and testbench

WB_SERIAL_MASTER -- requirements
Module: wb_serial_master

---
 rtl/wb_serial_master.sv | 194 +++++++++++++++++++
 tb/tb_wb_serial_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_serial_master.sv
// UART (8N1) command port driving a single Wishbone master: 'W' adr[4] dat[4] -> 06, 'R' adr[4] -> dat[4].
// Define WB_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT clocks (reply 0x15).
module wb_serial_master #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 4095 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
    $error("wb_serial_master: parameter out of range");
  end

  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  logic        rx_s1, rx_s2, rx_d;
  rx_state_t   rx_st;
  logic [11:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        byte_done, frame_err;

  state_t      state, state_nx;
  logic        is_wr;
  logic [1:0]  byte_cnt;
  logic [31:0] resp;
  logic [2:0]  resp_left;
  logic [11:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic        ack, timeout, tx_last;

  // Stop bit is judged combinationally so the FSM reacts on the sampling edge itself.
  assign byte_done = (rx_st == R_STOP) && (rx_cnt == BIT_LAST) && rx_s2;
  assign frame_err = (rx_st == R_STOP) && (rx_cnt == BIT_LAST) && !rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_d   <= 1'b1;
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      case (rx_st)
        R_IDLE: if (rx_d && !rx_s2) begin
          rx_st  <= R_START;
          rx_cnt <= '0;
        end
        R_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? R_IDLE : R_DATA;
        end else rx_cnt <= rx_cnt + 12'd1;
        R_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= R_STOP;
        end else rx_cnt <= rx_cnt + 12'd1;
        R_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          rx_st  <= R_IDLE;
        end else rx_cnt <= rx_cnt + 12'd1;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  assign ack     = wbm_ack_i && (state == BUS);
  assign tx_last = (state == RESP) && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9) && (resp_left == 3'd1);

`ifdef WB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state == BUS)   tmo_cnt <= tmo_cnt + 16'd1;
    else                     tmo_cnt <= '0;
  end
  assign timeout = (state == BUS) && (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (byte_done) state_nx = (rx_sh == 8'h57 || rx_sh == 8'h52) ? ADDR : RESP;
      ADDR: if (frame_err) state_nx = IDLE;
            else if (byte_done && byte_cnt == 2'd3) state_nx = is_wr ? DATA : BUS;
      DATA: if (frame_err) state_nx = IDLE;
            else if (byte_done && byte_cnt == 2'd3) state_nx = BUS;
      BUS:  if (ack || timeout) state_nx = RESP;
      RESP: if (tx_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    logic [7:0] tx_byte;
    logic [2:0] tx_idx;
    tx_byte   = resp[31:24];
    tx_idx    = 3'(tx_bit - 4'd1);
    wbm_cyc_o = (state == BUS);
    wbm_stb_o = wbm_cyc_o;
    wbm_we_o  = wbm_cyc_o && is_wr;
    wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
    busy      = (state != IDLE);
    tx        = 1'b1;
    if (state == RESP) begin
      if (tx_bit == 4'd0)      tx = 1'b0;
      else if (tx_bit != 4'd9) tx = tx_byte[tx_idx];
    end
  end

  // Reply bytes leave from resp[31:24]; resp shifts left one byte per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr     <= 1'b0;
      byte_cnt  <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      resp      <= '0;
      resp_left <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else begin
      if (state != RESP) begin
        tx_cnt <= '0;
        tx_bit <= '0;
      end
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (byte_done) begin
            is_wr     <= (rx_sh == 8'h57);
            resp      <= {8'h15, 24'h0};
            resp_left <= 3'd1;
          end
        end
        ADDR: if (byte_done) begin
          wbm_adr_o <= {wbm_adr_o[23:0], rx_sh};
          byte_cnt  <= byte_cnt + 2'd1;
        end
        DATA: if (byte_done) begin
          wbm_dat_o <= {wbm_dat_o[23:0], rx_sh};
          byte_cnt  <= byte_cnt + 2'd1;
        end
        BUS: if (ack) begin
          resp      <= is_wr ? {8'h06, 24'h0} : wbm_dat_i;
          resp_left <= is_wr ? 3'd1 : 3'd4;
        end else if (timeout) begin
          resp      <= {8'h15, 24'h0};
          resp_left <= 3'd1;
        end
        RESP: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            tx_bit    <= '0;
            resp      <= {resp[23:0], 8'h0};
            resp_left <= resp_left - 3'd1;
          end else tx_bit <= tx_bit + 4'd1;
        end else tx_cnt <= tx_cnt + 12'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: command-level model, per-cycle bus/tx rule checker, UART reply decoder.
module tb_wb_serial_master;
  localparam int CPB = 8;
`ifdef WB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic        tx, cyc, stb, we, busy;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack;

  wb_serial_master #(.CLKS_PER_BIT(CPB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [7:0]  cmd[$], exp_q[$], dec_q[$];
  logic        exp_we = 1'b0;
  logic [31:0] exp_adr = '0, exp_dat = '0;
  int          exp_nbus = 0, n_bus = 0, cyc_len = 0, last_len = 0, rst_epoch = 0;
  logic        prev_cyc = 1'b0;

  logic        ack_en = 1'b1, slave_ack = 1'b0, stray_ack = 1'b0;
  int          ack_delay = 0, wait_cnt = 0;
  logic [31:0] slave_rdata = '0;
  assign ack = slave_ack | stray_ack;

  // Slave: acks ack_delay cycles into the bus cycle, for exactly one cycle.
  always @(negedge clk) begin
    dat_i = slave_rdata;
    if (cyc && ack_en) begin
      slave_ack = (wait_cnt == ack_delay);
      wait_cnt++;
    end else begin
      slave_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Per-cycle rules: handshake consistency, bus fields vs model, tx idle whenever not busy.
  always @(negedge clk) begin
    logic ok;
    ok = (stb === cyc) && (sel === (cyc ? 4'hF : 4'h0)) && !(!cyc && we !== 1'b0)
         && !(cyc && !busy) && !(!busy && tx !== 1'b1);
    if (cyc === 1'b1)
      ok = ok && (we === exp_we) && (adr === exp_adr) && (!exp_we || dat_o === exp_dat);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cycle_rules t=%0t cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h busy=%b tx=%b required we=%b adr=%h dat=%h",
               $time, cyc, stb, we, sel, adr, dat_o, busy, tx, exp_we, exp_adr, exp_dat);
    end
    if (cyc === 1'b1) begin
      if (!prev_cyc) begin n_bus++; cyc_len = 0; end
      cyc_len++;
    end else if (prev_cyc) last_len = cyc_len;
    prev_cyc = (cyc === 1'b1);
  end

  // UART decoder on tx; frames cut short by a reset are dropped.
  always begin : uart_mon
    int ep;
    logic [7:0] b;
    logic ok;
    @(negedge clk);
    if (rst_n && tx === 1'b0) begin
      ep = rst_epoch;
      ok = 1'b1;
      repeat (CPB / 2 - 1) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
      if (ep == rst_epoch) begin
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL tx_frame byte=%h actual=bad_start_or_stop required=8N1", b);
        end
        dec_q.push_back(b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Command-level model: expected bus transaction and reply bytes for cmd[].
  task automatic model(input bit acked);
    exp_q.delete();
    if (cmd.size() == 9 && cmd[0] == 8'h57) begin
      exp_we  = 1'b1;
      exp_adr = {cmd[1], cmd[2], cmd[3], cmd[4]};
      exp_dat = {cmd[5], cmd[6], cmd[7], cmd[8]};
      exp_nbus++;
      exp_q.push_back(acked ? 8'h06 : 8'h15);
    end else if (cmd.size() == 5 && cmd[0] == 8'h52) begin
      exp_we  = 1'b0;
      exp_adr = {cmd[1], cmd[2], cmd[3], cmd[4]};
      exp_nbus++;
      if (acked) for (int i = 3; i >= 0; i--) exp_q.push_back(slave_rdata[8*i +: 8]);
      else exp_q.push_back(8'h15);
    end else exp_q.push_back(8'h15);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_cmd();
    foreach (cmd[i]) send_byte(cmd[i], 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_bound", 32'(busy), 32'd0);
  endtask

  task automatic run_cmd(input bit acked);
    model(acked);
    dec_q.delete();
    send_cmd();
    wait_idle();
    repeat (4) @(negedge clk);
    chk("reply_len", dec_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < dec_q.size()) chk($sformatf("reply_byte%0d", i), dec_q[i], exp_q[i]);
    chk("bus_count", n_bus, exp_nbus);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    rst_epoch++;
    #1;
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_stb", stb, 1'b0);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cyc", cyc, 1'b0);
    chk("reset_we", we, 1'b0);
    chk("reset_sel", sel, 4'h0);
    chk("reset_adr", adr, 32'h0);
    chk("reset_dat", dat_o, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    ack_delay = 2;
    cmd = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_cmd(1'b1);
    if (dec_q.size() > 0) chk("write_ack_literal", dec_q[0], 8'h06);
    chk("write_adr_literal", adr, 32'h30000004);
    chk("write_dat_literal", dat_o, 32'hDEADBEEF);

    slave_rdata = 32'h12345678;
    cmd = '{8'h52, 8'h30, 8'h00, 8'h00, 8'h00};
    run_cmd(1'b1);
    if (dec_q.size() == 4) chk("read_last_literal", dec_q[3], 8'h78);
    chk("read_adr_literal", adr, 32'h30000000);
    chk("dat_hold", dat_o, 32'hDEADBEEF);

    cmd = '{8'h41};
    run_cmd(1'b0);
    if (dec_q.size() > 0) chk("nak_literal", dec_q[0], 8'h15);

    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ack_busy", busy, 1'b0);
    chk("stray_ack_bus", n_bus, exp_nbus);

    dec_q.delete();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h57, 1'b0);
    repeat (20) @(negedge clk);
    chk("frame_err_busy", busy, 1'b0);
    chk("frame_err_reply", dec_q.size(), 0);
    chk("frame_err_bus", n_bus, exp_nbus);
    cmd = '{8'h41};
    run_cmd(1'b0);

`ifdef WB_TIMEOUT_EN
    ack_en = 1'b0;
    cmd = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
    run_cmd(1'b0);
    chk("timeout_cyc_len", last_len, TMO);
    ack_en = 1'b1;
    ack_delay = TMO - 1;
    slave_rdata = 32'hA5A50F0F;
    cmd = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h14};
    run_cmd(1'b1);
    chk("ack_wins_cyc_len", last_len, TMO);
`endif

    ack_en = 1'b0;
    cmd = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    model(1'b0);
    send_cmd();
`ifdef WB_TIMEOUT_EN
    repeat (5) @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    chk("cyc_hold_1000", 32'(cyc_len >= 1000 && cyc === 1'b1), 32'd1);
`endif
    async_reset();
    ack_en = 1'b1;

    cmd = '{8'h41};
    dec_q.delete();
    send_cmd();
    for (int n = 0; n < 200 && tx !== 1'b0; n++) @(negedge clk);
    chk("reply_started", tx, 1'b0);
    repeat (12) @(negedge clk);
    async_reset();
    chk("post_reset_bus", n_bus, exp_nbus);

    ack_delay = 0;
    cmd = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h2A};
    run_cmd(1'b1);
    chk("after_reset_adr", adr, 32'h00000008);
    chk("after_reset_dat", dat_o, 32'h0000002A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
